slave_frame_receiver_fsm: RTL and testbench
===========================================

Name: slave_frame_receiver_fsm

Overview:
- Target-board counterpart of the master processing FSM.
- The I2C target controller delivers 32-bit words in the order sent by the master: OP, operand B, operand A, RESULT. This block assembles those four words into one frame, publishes the frame, then forwards OP and RESULT to the local UART TX FIFO so the host can see them.
- It provides an inter-word timeout and an overrun flag so that a lost or extra word does not desynchronise later frames.

Parameters:
- TIMEOUT_CYCLES, 1000000, maximum clk cycles between accepted words inside a frame (10 ms at 100 MHz).
- TIMEOUT_W, 20, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- word_in  in  32  word from the I2C target controller
- word_valid  in  1  one-cycle strobe; word_in is valid in the same cycle
- uart_tx_full  in  1  UART TX FIFO full flag
- uart_wr  out  1  one-cycle write strobe to the UART TX FIFO
- uart_wr_data  out  8  byte to write
- frame_valid  out  1  one-cycle pulse when a complete frame is published
- frame_op  out  2  opcode (00 add, 01 sub, others pass-through)
- frame_a  out  32  operand A
- frame_b  out  32  operand B
- frame_result  out  32  result word
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  one-cycle pulse when a partial frame is dropped on timeout
- overrun_err  out  1  one-cycle pulse when a word is dropped in PUBLISH or TX
- state_out  out  3  encoded current state, for debug LEDs

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; byte index 0; internal capture registers 0.
- States and encodings: IDLE=0, GET_B=1, GET_A=2, GET_R=3, PUBLISH=4, TX=5, TX_GAP=6.
- IDLE:
  - On word_valid, capture word_in[1:0] as the opcode and go to GET_B.
  - word_in[31:2] is ignored unless the optional feature is enabled.
- GET_B, GET_A, GET_R:
  - On word_valid, capture the word into the B, A or R register respectively and advance to the next state. GET_R advances to PUBLISH.
  - The timeout counter clears on every accepted word and increments every cycle with no word.
  - When the counter reaches TIMEOUT_CYCLES: pulse timeout_err, go to IDLE, discard the partial frame. Frame outputs keep the last published frame.
  - If word_valid arrives in the same cycle the counter reaches its limit, the word wins: it is captured and no timeout is raised.
- PUBLISH (exactly one cycle):
  - frame_valid=1.
  - frame_op, frame_a, frame_b and frame_result update in this same cycle and are held until the next PUBLISH.
  - Latency: the RESULT word is sampled at cycle N; frame_valid is high at cycle N+1.
  - Next state is TX with byte index 0.
- TX:
  - Byte sequence: idx0 = {6'b0, op}, idx1..idx4 = result[31:24], [23:16], [15:8], [7:0].
  - If uart_tx_full=0, register uart_wr=1 and uart_wr_data=byte[idx] for the next cycle, then go to TX_GAP.
  - If uart_tx_full=1, stall in TX with uart_wr=0, indefinitely; there is no timeout in TX.
- TX_GAP (one cycle, lets the FIFO full flag settle):
  - Increment idx.
  - If idx was 4, go to IDLE; otherwise go to TX.
  - Writes are therefore spaced by at least 2 cycles.
- Overrun: word_valid during PUBLISH, TX or TX_GAP drops the word and pulses overrun_err the next cycle. State is unaffected.
- Reset asserted mid-frame or mid-TX returns immediately to the reset values. There is no partial UART write afterward; uart_wr deasserts asynchronously.
- busy = (state != IDLE).

Optional Feature:
- Macro: SLAVE_OP_CHECK_EN.
- Defined: in IDLE, an OP word with word_in[31:2] != 0 is rejected.
  - overrun_err pulses.
  - State stays IDLE and the word is not captured, which resynchronises the receiver after a lost OP word.
- Undefined: upper bits are ignored and any word in IDLE starts a frame.

Test Plan:
- Add frame: words 0x00000000, 0x40000000, 0x3F800000, 0x40400000 → frame_valid one cycle after the 4th strobe with op=00, b=0x40000000, a=0x3F800000, result=0x40400000. UART bytes 00,40,40,00,00; 5 uart_wr pulses, each ≥2 cycles apart.
- Backpressure: hold uart_tx_full=1 for 50 cycles after PUBLISH → no uart_wr and state_out=5 throughout. After release, all 5 bytes are sent in order.
- Timeout: TIMEOUT_CYCLES=100; send OP and B only → timeout_err pulses 100 cycles after B; state IDLE; previous frame outputs unchanged. A following full frame is received correctly.
- Boundary: deliver the A word exactly on the cycle the counter hits the limit → no timeout_err; frame completes.
- Overrun and reset: word_valid during TX → overrun_err pulse and TX bytes unchanged. Assert reset during GET_A → all outputs 0 and state IDLE.
- With SLAVE_OP_CHECK_EN: OP word 0x00000104 in IDLE → overrun_err pulses and state stays IDLE. Without the macro: the same word starts a frame with op=00.

Source files
------------

// File: rtl/slave_frame_receiver_fsm.sv
// slave_frame_receiver_fsm
// Target-side frame receiver: collects the four 32-bit words of a frame
// (OP, B, A, RESULT) from the I2C target controller, publishes the frame,
// then streams OP and RESULT as five bytes into the UART TX FIFO.
// An inter-word timeout drops partial frames; words arriving while the
// frame is being published or transmitted are dropped and flagged.
// Optional build macro: SLAVE_OP_CHECK_EN -- when defined, an OP word with
// non-zero upper bits is rejected in IDLE (flagged on overrun_err) so the
// receiver resynchronises after a lost OP word.

module slave_frame_receiver_fsm #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        uart_tx_full,
  output logic        uart_wr,
  output logic [7:0]  uart_wr_data,
  output logic        frame_valid,
  output logic [1:0]  frame_op,
  output logic [31:0] frame_a,
  output logic [31:0] frame_b,
  output logic [31:0] frame_result,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_A   = 3'd2,
    ST_GET_R   = 3'd3,
    ST_PUBLISH = 3'd4,
    ST_TX      = 3'd5,
    ST_TX_GAP  = 3'd6
  } state_t;

  // The counter holds the number of consecutive wordless cycles already
  // seen; the timeout fires on the cycle that would make it TIMEOUT_CYCLES.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_r, state_nxt_s;
  logic [TIMEOUT_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic [2:0]           idx_r, idx_nxt_s;
  logic [1:0]           op_r;
  logic [31:0]          b_r, a_r;

  logic op_ok_s, op_cap_s, b_cap_s, a_cap_s, r_cap_s;
  logic tmo_s, ovr_s, wr_s;

  logic        uart_wr_r, frame_valid_r, busy_r, timeout_err_r, overrun_err_r;
  logic [7:0]  uart_wr_data_r;
  logic [1:0]  frame_op_r;
  logic [31:0] frame_a_r, frame_b_r, frame_result_r;

  // Byte to send for a given TX index: OP first, then RESULT MSB first.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx,
                                         input logic [1:0] op,
                                         input logic [31:0] res);
    case (idx)
      3'd0:    tx_byte = {6'b000000, op};
      3'd1:    tx_byte = res[31:24];
      3'd2:    tx_byte = res[23:16];
      3'd3:    tx_byte = res[15:8];
      3'd4:    tx_byte = res[7:0];
      default: tx_byte = 8'h00;
    endcase
  endfunction

`ifdef SLAVE_OP_CHECK_EN
  assign op_ok_s = (word_in[31:2] == 30'd0);
`else
  assign op_ok_s = 1'b1;
`endif

  // Next-state, timeout counter, byte index and capture/strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    idx_nxt_s     = idx_r;
    op_cap_s      = 1'b0;
    b_cap_s       = 1'b0;
    a_cap_s       = 1'b0;
    r_cap_s       = 1'b0;
    tmo_s         = 1'b0;
    ovr_s         = 1'b0;
    wr_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_nxt_s = '0;
        if (word_valid && op_ok_s) begin
          op_cap_s    = 1'b1;
          state_nxt_s = ST_GET_B;
        end else if (word_valid) begin
          ovr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_B, ST_GET_A, ST_GET_R: begin
        // A word arriving on the limit cycle takes priority over timeout.
        if (word_valid) begin
          tmo_cnt_nxt_s = '0;
          if (state_r == ST_GET_B) begin
            b_cap_s     = 1'b1;
            state_nxt_s = ST_GET_A;
          end else if (state_r == ST_GET_A) begin
            a_cap_s     = 1'b1;
            state_nxt_s = ST_GET_R;
          end else begin
            r_cap_s     = 1'b1;
            state_nxt_s = ST_PUBLISH;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_s         = 1'b1;
          tmo_cnt_nxt_s = '0;
          state_nxt_s   = ST_IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_PUBLISH: begin
        ovr_s       = word_valid;
        idx_nxt_s   = 3'd0;
        state_nxt_s = ST_TX;
      end
      ST_TX: begin
        ovr_s = word_valid;
        if (!uart_tx_full) begin
          wr_s        = 1'b1;
          state_nxt_s = ST_TX_GAP;
        end else begin
          state_nxt_s = ST_TX;
        end
      end
      ST_TX_GAP: begin
        ovr_s     = word_valid;
        idx_nxt_s = idx_r + 3'd1;
        if (idx_r == 3'd4) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_TX;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        tmo_cnt_nxt_s = '0;
        idx_nxt_s     = 3'd0;
      end
    endcase
  end

  // State, counter, index and internal word capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= '0;
      idx_r     <= 3'd0;
      op_r      <= 2'b00;
      b_r       <= 32'h0000_0000;
      a_r       <= 32'h0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      if (op_cap_s) op_r <= word_in[1:0];
      if (b_cap_s)  b_r  <= word_in;
      if (a_cap_s)  a_r  <= word_in;
    end
  end

  // Registered outputs: frame publication, UART write strobe and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_wr_r      <= 1'b0;
      uart_wr_data_r <= 8'h00;
      frame_valid_r  <= 1'b0;
      frame_op_r     <= 2'b00;
      frame_a_r      <= 32'h0000_0000;
      frame_b_r      <= 32'h0000_0000;
      frame_result_r <= 32'h0000_0000;
      busy_r         <= 1'b0;
      timeout_err_r  <= 1'b0;
      overrun_err_r  <= 1'b0;
    end else begin
      uart_wr_r     <= wr_s;
      frame_valid_r <= r_cap_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      timeout_err_r <= tmo_s;
      overrun_err_r <= ovr_s;
      if (wr_s) uart_wr_data_r <= tx_byte(idx_r, frame_op_r, frame_result_r);
      // The whole frame lands together so it is coherent during PUBLISH.
      if (r_cap_s) begin
        frame_op_r     <= op_r;
        frame_a_r      <= a_r;
        frame_b_r      <= b_r;
        frame_result_r <= word_in;
      end
    end
  end

  assign uart_wr      = uart_wr_r;
  assign uart_wr_data = uart_wr_data_r;
  assign frame_valid  = frame_valid_r;
  assign frame_op     = frame_op_r;
  assign frame_a      = frame_a_r;
  assign frame_b      = frame_b_r;
  assign frame_result = frame_result_r;
  assign busy         = busy_r;
  assign timeout_err  = timeout_err_r;
  assign overrun_err  = overrun_err_r;
  assign state_out    = state_r;

endmodule

// File: tb/tb_slave_frame_receiver_fsm.sv
// Directed self-checking bench for slave_frame_receiver_fsm (TIMEOUT_CYCLES=100).
module tb_slave_frame_receiver_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = 32'h0;
  logic        word_valid = 1'b0;
  logic        uart_tx_full = 1'b0;
  logic        uart_wr;
  logic [7:0]  uart_wr_data;
  logic        frame_valid;
  logic [1:0]  frame_op;
  logic [31:0] frame_a, frame_b, frame_result;
  logic        busy, timeout_err, overrun_err;
  logic [2:0]  state_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap_bytes [0:7];
  int         cap_n;
  int         cap_min_gap;

  logic [113:0] all_out;
  assign all_out = {uart_wr, uart_wr_data, frame_valid, frame_op, frame_a, frame_b,
                    frame_result, busy, timeout_err, overrun_err, state_out};

  slave_frame_receiver_fsm #(.TIMEOUT_CYCLES(100), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .uart_tx_full(uart_tx_full), .uart_wr(uart_wr), .uart_wr_data(uart_wr_data),
    .frame_valid(frame_valid), .frame_op(frame_op), .frame_a(frame_a),
    .frame_b(frame_b), .frame_result(frame_result), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    word_in    = 32'h0;
  endtask

  // Record UART writes until the FSM is back in IDLE (bounded).
  task automatic capture_tx(input int max_cycles);
    int last_c;
    cap_n = 0;
    cap_min_gap = 1000;
    last_c = -1000;
    for (int i = 0; i < 8; i++) cap_bytes[i] = 8'h00;
    for (int c = 0; c < max_cycles; c++) begin
      if (uart_wr === 1'b1) begin
        if (cap_n < 8) cap_bytes[cap_n] = uart_wr_data;
        if (c - last_c < cap_min_gap) cap_min_gap = c - last_c;
        last_c = c;
        cap_n++;
      end
      if (cap_n > 0 && state_out == 3'd0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++; if (all_out !== 114'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    reset = 1'b0;
    tick(); tick();
    n_vec++; if (all_out !== 114'd0) begin n_err++; $display("FAIL post_reset_idle: got %h expected 0", all_out); end
  endtask

  task automatic test_add_frame();
    logic [7:0] exp [0:4];
    exp = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
    send_word(32'h0000_0000);
    n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL add_state_getb: got %0d expected 1", state_out); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b expected 1", busy); end
    send_word(32'h4000_0000);
    send_word(32'h3F80_0000);
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL add_fv_early: got %b expected 0", frame_valid); end
    send_word(32'h4040_0000);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL add_frame_valid: got %b expected 1", frame_valid); end
    n_vec++; if (state_out !== 3'd4) begin n_err++; $display("FAIL add_state_publish: got %0d expected 4", state_out); end
    n_vec++; if (frame_op !== 2'b00) begin n_err++; $display("FAIL add_op: got %b expected 00", frame_op); end
    n_vec++; if (frame_b !== 32'h4000_0000) begin n_err++; $display("FAIL add_b: got %h expected 40000000", frame_b); end
    n_vec++; if (frame_a !== 32'h3F80_0000) begin n_err++; $display("FAIL add_a: got %h expected 3f800000", frame_a); end
    n_vec++; if (frame_result !== 32'h4040_0000) begin n_err++; $display("FAIL add_result: got %h expected 40400000", frame_result); end
    tick();
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL add_fv_pulse: got %b expected 0", frame_valid); end
    n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL add_state_tx: got %0d expected 5", state_out); end
    n_vec++; if (frame_result !== 32'h4040_0000) begin n_err++; $display("FAIL add_result_held: got %h expected 40400000", frame_result); end
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL add_wr_count: got %0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cap_bytes[i] !== exp[i]) begin n_err++; $display("FAIL add_byte%0d: got %h expected %h", i, cap_bytes[i], exp[i]); end
    end
    n_vec++; if (cap_min_gap < 2) begin n_err++; $display("FAIL add_wr_gap: got %0d expected >=2", cap_min_gap); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_sub_frame();
    logic [7:0] exp [0:4];
    exp = '{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    send_word(32'hCAFE_BABE);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL sub_frame_valid: got %b expected 1", frame_valid); end
    n_vec++; if (frame_op !== 2'b01) begin n_err++; $display("FAIL sub_op: got %b expected 01", frame_op); end
    n_vec++; if (frame_b !== 32'h1234_5678) begin n_err++; $display("FAIL sub_b: got %h expected 12345678", frame_b); end
    n_vec++; if (frame_a !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL sub_a: got %h expected 9abcdef0", frame_a); end
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL sub_wr_count: got %0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cap_bytes[i] !== exp[i]) begin n_err++; $display("FAIL sub_byte%0d: got %h expected %h", i, cap_bytes[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [0:4];
    int bad;
    exp = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bad = 0;
    send_word(32'h0000_0002);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    uart_tx_full = 1'b1;
    send_word(32'hDEAD_BEEF);
    for (int c = 0; c < 50; c++) begin
      tick();
      if (uart_wr !== 1'b0 || state_out !== 3'd5) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bp_stall: got %0d bad cycles expected 0", bad); end
    uart_tx_full = 1'b0;
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL bp_wr_count: got %0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cap_bytes[i] !== exp[i]) begin n_err++; $display("FAIL bp_byte%0d: got %h expected %h", i, cap_bytes[i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [0:4];
    int k;
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_word(32'h0000_0003);
    send_word(32'h7777_7777);
    k = 1;
    while (k <= 150) begin
      tick();
      if (timeout_err === 1'b1) break;
      k++;
    end
    n_vec++; if (k !== 100) begin n_err++; $display("FAIL tmo_latency: got %0d cycles expected 100", k); end
    n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL tmo_state: got %0d expected 0", state_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    n_vec++; if (frame_op !== 2'b10) begin n_err++; $display("FAIL tmo_op_held: got %b expected 10", frame_op); end
    n_vec++; if (frame_b !== 32'h1111_1111) begin n_err++; $display("FAIL tmo_b_held: got %h expected 11111111", frame_b); end
    n_vec++; if (frame_result !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tmo_result_held: got %h expected deadbeef", frame_result); end
    tick();
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got %b expected 0", timeout_err); end
    send_word(32'h0000_0001);
    send_word(32'h0000_0005);
    send_word(32'h0000_0003);
    send_word(32'h0000_0002);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL tmo_next_fv: got %b expected 1", frame_valid); end
    n_vec++; if (frame_b !== 32'h0000_0005) begin n_err++; $display("FAIL tmo_next_b: got %h expected 00000005", frame_b); end
    n_vec++; if (frame_a !== 32'h0000_0003) begin n_err++; $display("FAIL tmo_next_a: got %h expected 00000003", frame_a); end
    capture_tx(40);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cap_bytes[i] !== exp[i]) begin n_err++; $display("FAIL tmo_next_byte%0d: got %h expected %h", i, cap_bytes[i], exp[i]); end
    end
  endtask

  task automatic test_boundary();
    int seen;
    seen = 0;
    send_word(32'h0000_0000);
    send_word(32'h0BAD_F00D);
    for (int c = 0; c < 99; c++) begin
      tick();
      if (timeout_err !== 1'b0) seen++;
    end
    send_word(32'h1357_9BDF);
    n_vec++; if (seen !== 0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL bnd_no_timeout: got %0d/%b expected 0/0", seen, timeout_err); end
    n_vec++; if (state_out !== 3'd3) begin n_err++; $display("FAIL bnd_state_getr: got %0d expected 3", state_out); end
    send_word(32'h2468_ACE0);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL bnd_fv: got %b expected 1", frame_valid); end
    n_vec++; if (frame_a !== 32'h1357_9BDF) begin n_err++; $display("FAIL bnd_a: got %h expected 13579bdf", frame_a); end
    n_vec++; if (frame_result !== 32'h2468_ACE0) begin n_err++; $display("FAIL bnd_result: got %h expected 2468ace0", frame_result); end
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL bnd_wr_count: got %0d expected 5", cap_n); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [0:4];
    exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_word(32'h0000_0000);
    send_word(32'hAAAA_5555);
    send_word(32'h5555_AAAA);
    send_word(32'h0102_0304);
    tick();
    n_vec++; if (state_out !== 3'd5) begin n_err++; $display("FAIL ovr_state_tx: got %0d expected 5", state_out); end
    send_word(32'hFFFF_FFFF);
    n_vec++; if (overrun_err !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b expected 1", overrun_err); end
    n_vec++; if (state_out !== 3'd6) begin n_err++; $display("FAIL ovr_state_gap: got %0d expected 6", state_out); end
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL ovr_wr_count: got %0d expected 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cap_bytes[i] !== exp[i]) begin n_err++; $display("FAIL ovr_byte%0d: got %h expected %h", i, cap_bytes[i], exp[i]); end
    end
    n_vec++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL ovr_pulse_end: got %b expected 0", overrun_err); end
    n_vec++; if (frame_result !== 32'h0102_0304) begin n_err++; $display("FAIL ovr_result_kept: got %h expected 01020304", frame_result); end
  endtask

  task automatic test_reset_mid();
    int found;
    int bad;
    send_word(32'h0000_0001);
    send_word(32'h0000_00AA);
    n_vec++; if (state_out !== 3'd2) begin n_err++; $display("FAIL rst_state_geta: got %0d expected 2", state_out); end
    reset = 1'b1;
    #2;
    n_vec++; if (all_out !== 114'd0) begin n_err++; $display("FAIL rst_mid_outputs: got %h expected 0", all_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL rst_mid_idle: got %0d expected 0", state_out); end
    send_word(32'h0000_0000);
    send_word(32'h0000_0011);
    send_word(32'h0000_0022);
    send_word(32'h0000_0033);
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (uart_wr === 1'b1) begin found = 1; break; end
      tick();
    end
    n_vec++; if (found !== 1) begin n_err++; $display("FAIL rst_tx_wr_seen: got %0d expected 1", found); end
    reset = 1'b1;
    #1;
    n_vec++; if (uart_wr !== 1'b0 || state_out !== 3'd0) begin n_err++; $display("FAIL rst_tx_async: got wr=%b st=%0d expected wr=0 st=0", uart_wr, state_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (uart_wr !== 1'b0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rst_tx_no_partial: got %0d writes expected 0", bad); end
  endtask

  task automatic test_op_check();
    send_word(32'h0000_0104);
`ifdef SLAVE_OP_CHECK_EN
    n_vec++; if (overrun_err !== 1'b1) begin n_err++; $display("FAIL opchk_reject_pulse: got %b expected 1", overrun_err); end
    n_vec++; if (state_out !== 3'd0) begin n_err++; $display("FAIL opchk_stay_idle: got %0d expected 0", state_out); end
    send_word(32'h0000_0003);
    send_word(32'h0000_0044);
    send_word(32'h0000_0055);
    send_word(32'h0000_0066);
    n_vec++; if (frame_op !== 2'b11) begin n_err++; $display("FAIL opchk_resync_op: got %b expected 11", frame_op); end
    n_vec++; if (frame_b !== 32'h0000_0044) begin n_err++; $display("FAIL opchk_resync_b: got %h expected 00000044", frame_b); end
`else
    n_vec++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL opchk_no_flag: got %b expected 0", overrun_err); end
    n_vec++; if (state_out !== 3'd1) begin n_err++; $display("FAIL opchk_start: got %0d expected 1", state_out); end
    send_word(32'h0000_0044);
    send_word(32'h0000_0055);
    send_word(32'h0000_0066);
    n_vec++; if (frame_op !== 2'b00) begin n_err++; $display("FAIL opchk_op: got %b expected 00", frame_op); end
    n_vec++; if (frame_b !== 32'h0000_0044) begin n_err++; $display("FAIL opchk_b: got %h expected 00000044", frame_b); end
`endif
    capture_tx(40);
    n_vec++; if (cap_n !== 5) begin n_err++; $display("FAIL opchk_wr_count: got %0d expected 5", cap_n); end
  endtask

  initial begin
    test_reset();
    test_add_frame();
    test_sub_frame();
    test_backpressure();
    test_timeout();
    test_boundary();
    test_overrun();
    test_reset_mid();
    test_op_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
